// File: rtl/writeback_stage.sv
// MEM/WB pipeline register: picks the retiring result, drives the register file
// write port, bypasses the in-flight write to decode and counts committed writes.
module writeback_stage #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             flush,
   input  logic             mem_valid,
   input  logic             mem_le,
   input  logic [4:0]       mem_rd,
   input  logic [1:0]       mem_src,
   input  logic [31:0]      mem_alu,
   input  logic [31:0]      mem_load,
   input  logic [31:0]      mem_pc,
   input  logic [4:0]       id_ra,
   input  logic [4:0]       id_rb,
   input  logic [4:0]       id_rd,
   input  logic [31:0]      rf_pa,
   input  logic [31:0]      rf_pb,
   input  logic [31:0]      rf_pd,
   output logic [31:0]      PW,
   output logic [4:0]       RW,
   output logic             LE,
   output logic [31:0]      fwd_pa,
   output logic [31:0]      fwd_pb,
   output logic [31:0]      fwd_pd,
   output logic [CNT_W-1:0] wb_count
);

   logic             r_valid;
   logic             r_le;
   logic [4:0]       r_rd;
   logic [31:0]      r_data;
   logic [CNT_W-1:0] r_count;
   logic [31:0]      w_result;
   logic             w_le;
   logic             w_commit;

   always_comb begin
      w_result = 32'h0;
      case (mem_src)
         2'b00:   w_result = mem_alu;
         2'b01:   w_result = mem_load;
         2'b10:   w_result = mem_pc;
         default: w_result = 32'h0;
      endcase
   end

   // A write is counted once, on the edge where it leaves the stage (not on stalled repeats).
   assign w_le     = r_valid & r_le & (r_rd != 5'd0);
   assign w_commit = w_le & (~stall | flush);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid <= 1'b0;
         r_le    <= 1'b0;
         r_rd    <= 5'd0;
         r_data  <= 32'h0;
         r_count <= '0;
      end else begin
         if (w_commit)
            r_count <= r_count + CNT_W'(1);
         if (flush) begin
            r_valid <= 1'b0;
            r_le    <= 1'b0;
            r_rd    <= 5'd0;
            r_data  <= 32'h0;
         end else if (!stall) begin
            r_valid <= mem_valid;
            r_le    <= mem_le & (mem_src != 2'b11);
            r_rd    <= mem_rd;
            r_data  <= w_result;
         end
      end
   end

   assign PW       = r_data;
   assign RW       = r_rd;
   assign LE       = w_le;
   assign wb_count = r_count;

   // The register file only sees this write after the next edge, so forward it meanwhile.
   assign fwd_pa = (id_ra == 5'd0) ? 32'h0 : ((w_le && id_ra == r_rd) ? r_data : rf_pa);
   assign fwd_pb = (id_rb == 5'd0) ? 32'h0 : ((w_le && id_rb == r_rd) ? r_data : rf_pb);
   assign fwd_pd = (id_rd == 5'd0) ? 32'h0 : ((w_le && id_rd == r_rd) ? r_data : rf_pd);

endmodule
